// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional
// parity bit, one stop bit. One serial bit per CLK cycle. TX_OUT and Busy
// are registered and change on the same edge as the state register.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even parity is the XOR of all bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  odd);
    return (^d) ^ odd;
  endfunction

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q,     tx_d;
  logic                  busy_q,   busy_d;
  logic [CNT_W-1:0]      cnt_inc_s;

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // Next-state, next-output and datapath logic. Outputs are computed for the
  // state being entered so the registered values line up with the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    cnt_inc_s = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          // Latch the word and config; parity is fixed for the whole frame.
          state_d   = S_START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = calc_parity(P_DATA, PAR_TYP);
          cnt_d     = {CNT_W{1'b0}};
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_START: begin
        state_d = S_DATA;
        cnt_d   = {CNT_W{1'b0}};
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end

      S_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          state_d = S_DATA;
          cnt_d   = cnt_inc_s;
          tx_d    = data_q[cnt_inc_s];
        end
      end

      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      S_STOP: begin
        // Always pass through IDLE so frames are separated by an idle bit.
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; async reset aborts any frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a frame-level reference model.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int vectors;
  int miscompares;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: bit i of the serial frame for word w.
  function automatic logic exp_bit(input logic [7:0] w, input logic pe,
                                   input logic pt, input int i);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(w[k]);
    if (i == 0) return 1'b0;
    if (i <= 8) return w[i-1];
    if (pe && i == 9) return ((ones % 2) == 1) ^ pt;
    return 1'b1;
  endfunction

  // Drive one frame request (caller sits just after a negedge) and check
  // every bit plus the idle cycle after it. hold keeps Data_Valid high;
  // poke_at >= 0 disturbs the inputs mid-frame with a second request.
  task automatic run_frame(input logic [7:0] w, input logic pe, input logic pt,
                           input bit hold, input int poke_at, input string name);
    int len;
    len = pe ? 11 : 10;
    P_DATA = w; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== exp_bit(w, pe, pt, i) || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s bit %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=1",
                 name, i, TX_OUT, Busy, exp_bit(w, pe, pt, i));
      end
      if (i == 0 && !hold) Data_Valid = 1'b0;
      if (i == poke_at) begin
        P_DATA = 8'hFF; PAR_EN = ~pe; PAR_TYP = ~pt; Data_Valid = 1'b1;
      end
      if (i == poke_at + 1) Data_Valid = 1'b0;
    end
    @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0",
               name, TX_OUT, Busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset cyc %0d: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0",
                 i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_no_parity();
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, "a5_nopar");
  endtask

  task automatic test_parity();
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, "a5_even");
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1, "a5_odd");
    run_frame(8'h80, 1'b1, 1'b0, 1'b0, -1, "80_even");
  endtask

  task automatic test_isolation();
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3, "3c_poked");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL no_second_frame cyc %0d: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0",
                 i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, "b2b_0");
    run_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, "b2b_1");
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, "b2b_2");
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    w = 8'($urandom);
    P_DATA = w; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== exp_bit(w, 1'b1, 1'b0, i) || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL pre_abort bit %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=1",
                 i, TX_OUT, Busy, exp_bit(w, 1'b1, 1'b0, i));
      end
      if (i == 0) Data_Valid = 1'b0;
    end
    // Now in the 4th data bit; assert reset between clock edges.
    #1 RST = 1'b0;
    #1;
    vectors++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_abort: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort_idle: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1, "post_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1, "random");
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_no_parity();
    test_parity();
    test_isolation();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
